// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - shared state encoding and reset values for count_ctrl
package count_ctrl_pkg;

  // Two-state mode machine: manual stepping or free-running auto mode.
  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_e;

  // Counter direction after reset is up; the block starts in manual mode.
  localparam logic UPDOWN_RST  = 1'b1;
  localparam logic RUNNING_RST = 1'b0;

endpackage

// File: rtl/count_ctrl_if.sv
// rtl/count_ctrl_if.sv - button inputs and counter-control outputs of count_ctrl
interface count_ctrl_if;

  logic BtnStep;
  logic BtnDir;
  logic BtnRun;
  logic Enable;
  logic UpDown;
  logic Running;

  // Driver side: owns the raw buttons, observes the counter controls.
  modport master (
    output BtnStep, BtnDir, BtnRun,
    input  Enable, UpDown, Running
  );

  // Controller side.
  modport slave (
    input  BtnStep, BtnDir, BtnRun,
    output Enable, UpDown, Running
  );

endinterface

// File: rtl/count_ctrl_btn_debounce.sv
// rtl/count_ctrl_btn_debounce.sv - synchronizer, debouncer and press-edge detector for one button
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Raw,
  output logic Level,
  output logic Press
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronized level differs from the accepted
  // level; a match restarts the count, the DB_CYCLES-th mismatch is accepted.
  always_comb begin
    sync1_d = Raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, debounce and press flops; reset discards any pending press.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Level = level_q;
  assign Press = press_q;

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - button-driven enable/direction controller for a 4-bit up/down counter
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV  = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  count_ctrl_if.slave  bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic step_press, dir_press, run_press;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              enable_q, enable_d;
  logic              updown_q, updown_d;
  logic              running_q, running_d;
  logic              wrap;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .Clk(Clk), .Rst(Rst), .Raw(bus.BtnStep), .Level(), .Press(step_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .Clk(Clk), .Rst(Rst), .Raw(bus.BtnDir), .Level(), .Press(dir_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .Clk(Clk), .Rst(Rst), .Raw(bus.BtnRun), .Level(), .Press(run_press)
  );

  // Mode state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Each Run press flips between manual and auto mode.
  always_comb begin
    state_d = state_q;
    if (run_press) begin
      state_d = (state_q == MANUAL) ? AUTO : MANUAL;
    end
  end

  // Tick divider, enable generation and direction toggle; leaving auto mode
  // clears the divider and swallows a pulse that would coincide with the exit.
  always_comb begin
    wrap      = 1'b0;
    tick_d    = '0;
    enable_d  = 1'b0;
    updown_d  = updown_q ^ dir_press;
    running_d = (state_d == AUTO);
    if (state_q == AUTO) begin
      wrap     = (tick_q == TICK_LAST);
      tick_d   = wrap ? '0 : tick_q + TICK_W'(1);
      enable_d = wrap;
      if (run_press) begin
        tick_d   = '0;
        enable_d = 1'b0;
      end
    end else begin
      enable_d = step_press;
    end
  end

  // Output and divider flops; outputs come straight from these registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tick_q    <= '0;
      enable_q  <= 1'b0;
      updown_q  <= UPDOWN_RST;
      running_q <= RUNNING_RST;
    end else begin
      tick_q    <= tick_d;
      enable_q  <= enable_d;
      updown_q  <= updown_d;
      running_q <= running_d;
    end
  end

  assign bus.Enable  = enable_q;
  assign bus.UpDown  = updown_q;
  assign bus.Running = running_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - directed vector bench for count_ctrl
module tb_count_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  count_ctrl_if bus ();

  count_ctrl #(.DB_CYCLES(4), .TICK_DIV(8)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        step;
    logic        dir;
    logic        run;
    logic        rst;
    logic        en;
    logic        ud;
    logic        running;
    logic [63:0] name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic s, d, r, rs, e, u, rn, input logic [63:0] nm);
    vec_t v;
    v.step = s; v.dir = d; v.run = r; v.rst = rs;
    v.en = e; v.ud = u; v.running = rn; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input logic e, u, rn, input logic [63:0] nm);
    n_vec++;
    if ({bus.Enable, bus.UpDown, bus.Running} !== {e, u, rn}) begin
      n_bad++;
      $display("FAIL %0s #%0d: got en=%b ud=%b run=%b, expected en=%b ud=%b run=%b",
               nm, n_vec, bus.Enable, bus.UpDown, bus.Running, e, u, rn);
    end
  endtask

  // Drive one cycle of inputs, let the next rising edge take them, then check.
  task automatic cyc(input logic s, d, r, rs, e, u, rn, input logic [63:0] nm);
    bus.BtnStep = s;
    bus.BtnDir  = d;
    bus.BtnRun  = r;
    Rst         = rs;
    @(posedge Clk);
    #1;
    check(e, u, rn, nm);
  endtask

  initial begin
    bus.BtnStep = 1'b0;
    bus.BtnDir  = 1'b0;
    bus.BtnRun  = 1'b0;

    // Reset held with all buttons toggling.
    for (int i = 0; i < 6; i++) add(i[0], ~i[0], i[0], 1'b0, 1'b0, 1'b1, 1'b0, "reset");
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "idle");
    // Bouncy step press: six alternating cycles, then held.
    for (int i = 0; i < 6; i++) add(~i[0], 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "bounce");
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, 1'b0, 1'b1, i == 6, 1'b1, 1'b0, "step");
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "steprel");
    // Two clean Dir presses.
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, i < 6, 1'b0, "dir1");
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "dir1rel");
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, i >= 6, 1'b0, "dir2");
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "dir2rel");

    foreach (vecs[i]) begin
      cyc(vecs[i].step, vecs[i].dir, vecs[i].run, vecs[i].rst,
          vecs[i].en, vecs[i].ud, vecs[i].running, vecs[i].name);
    end

    // Auto mode: Run press enters AUTO after 6 edges, pulses every 8 cycles;
    // a Step press pulse at edge 21 must be ignored.
    for (int k = 0; k < 34; k++) begin
      cyc(1'b0 | (k >= 16), 1'b0, k < 10, 1'b1,
          (k == 14) || (k == 22) || (k == 30), 1'b1, k >= 6, "auto");
    end

    // Reset mid-operation with BtnStep held: immediate clear.
    Rst = 1'b0;
    #1;
    check(1'b0, 1'b1, 1'b0, "rstnow");
    n_vec++;
    if (dut.tick_q !== '0) begin
      n_bad++;
      $display("FAIL rsttick: got tick=%0d, expected tick=0", dut.tick_q);
    end
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rsthold");
    // Release: the held button yields exactly one pulse.
    for (int k = 0; k < 13; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, k == 6, 1'b1, 1'b0, "rstrel");
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "steprel2");

    // Simultaneous Dir and Step presses in MANUAL.
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1, k == 6, k < 6, 1'b0, "simul");
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "simulrel");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4: consecutive stable synchronized samples required to accept a button level change (range 2..2^16).
REQ-002 The block SHALL have parameter TICK_DIV, default 8: clock cycles between auto-run Enable pulses (range 2..2^24).
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset (Rst=0 resets).
REQ-005 The block SHALL have port BtnStep, input, 1 bit: raw, asynchronous, bouncy step pushbutton (1 = pressed).
REQ-006 The block SHALL have port BtnDir, input, 1 bit: raw pushbutton; each press toggles the count direction.
REQ-007 The block SHALL have port BtnRun, input, 1 bit: raw pushbutton; each press toggles between manual and auto-run modes.
REQ-008 The block SHALL have port Enable, output, 1 bit: count-enable pulse for the downstream 4-bit up/down counter.
REQ-009 The block SHALL have port UpDown, output, 1 bit: direction for the downstream counter (1 = up, 0 = down).
REQ-010 The block SHALL have port Running, output, 1 bit: 1 while the block is in auto-run mode.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer followed by a debouncer whose output takes the synchronized level only after DB_CYCLES consecutive cycles at that level; any mismatch SHALL restart the stability count.
REQ-012 A rising edge on a debounced button SHALL produce an internal press pulse exactly one cycle wide; a release SHALL produce no pulse, and a held button SHALL produce no further pulses.
REQ-013 The FSM SHALL have two states, MANUAL and AUTO: a Run press in MANUAL SHALL go to AUTO, a Run press in AUTO SHALL go to MANUAL, and no other transitions SHALL exist.
REQ-014 Running SHALL be registered and equal 1 exactly when the state is AUTO.
REQ-015 In MANUAL, a Step press SHALL drive Enable high for exactly one cycle, in the cycle after the press pulse.
REQ-016 In AUTO, a tick counter SHALL count 0..TICK_DIV-1 and wrap; Enable SHALL be high for one cycle each time the counter wraps, so the first pulse comes TICK_DIV cycles after entering AUTO.
REQ-017 In AUTO, Step presses SHALL be ignored.
REQ-018 Entering MANUAL SHALL clear the tick counter to 0; leaving AUTO on the same cycle as a wrap SHALL suppress that Enable pulse.
REQ-019 A Dir press SHALL toggle UpDown on the clock edge after the press pulse, in either mode.
REQ-020 If a Dir press and an Enable-producing event fall in the same cycle, UpDown and Enable SHALL change on the same edge, so the downstream counter steps in the new direction.
REQ-021 Enable and UpDown SHALL be driven directly from flops, with no combinational path from the inputs.

Reset
REQ-022 While Rst=0, the block SHALL immediately force Enable=0, UpDown=1, Running=0, state=MANUAL, tick counter=0, all synchronizer/debounce flops=0 and stability counters=0.
REQ-023 Assertion of Rst in the middle of a press or a debounce SHALL discard that press.
REQ-024 After Rst is released, a button already held SHALL produce exactly one press, once it has been stable for DB_CYCLES cycles.

Structure
REQ-025 The state encoding (MANUAL, AUTO) and the reset values of UpDown and Running SHALL be defined in a shared package, count_ctrl_pkg.
REQ-026 The design SHALL use one sub-module, btn_debounce (parameter DB_CYCLES; ports Clk, Rst, Raw, Level, Press), instantiated three times.

Verification
REQ-027 The bench SHALL check reset: with Rst=0 and all buttons toggling, Enable=0, UpDown=1 and Running=0 at all times.
REQ-028 The bench SHALL check a bouncy step press: BtnStep toggling every cycle for 6 cycles and then held high, giving exactly one Enable pulse, 1 cycle wide, 2+4+1 cycles after the last bounce edge.
REQ-029 The bench SHALL check direction: one clean BtnDir press gives UpDown 1->0, and a second press gives 0->1; Enable stays 0 throughout.
REQ-030 The bench SHALL check auto mode: a Run press gives Running=1 and Enable pulses every 8 cycles (TICK_DIV=8), with Step presses in AUTO adding no pulses.
REQ-031 The bench SHALL check the simultaneous case: Dir and Step presses arriving in the same cycle in MANUAL give UpDown toggled and Enable=1 on the same edge.
REQ-032 The bench SHALL check reset mid-operation: Rst=0 for 3 cycles in AUTO with BtnStep held gives Running=0 and the tick counter cleared, then after release exactly one Enable pulse from the held button.
